// File: rtl/signal_meas_pkg.sv
// Shared types, defaults and helpers for the signal measurement block.
package signal_meas_pkg;

    // Hysteresis detector state encoding.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } det_st_e;

    // Default parameter values.
    localparam int DEF_DW        = 10;
    localparam int DEF_WIN_CYC   = 1000000;
    localparam int DEF_FRE_WIN   = 5000000;
    localparam int DEF_FRE_SCALE = 10;
    localparam int DEF_HYST      = 4;
    localparam int DEF_MIN_PP    = 8;
    localparam int DEF_CW        = 24;

    // a + b clamped to lim (operands are small sample-domain values).
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

    // a - b clamped at zero.
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/signal_meas_det.sv
// Hysteresis rising-crossing detector around the published midpoint.
module hyst_edge_det
    import signal_meas_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int HYST = DEF_HYST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic [DW-1:0] mid,
    input  logic          arm,
    input  logic          en,
    output logic          rise
);

    localparam int unsigned MAXV = (32'd1 << DW) - 32'd1;

    det_st_e       state_q, state_d;
    logic [DW-1:0] hi_th, lo_th;

    // Thresholds saturate at the ends of the sample range.
    assign hi_th = DW'(sat_add(32'(mid), 32'(HYST), MAXV));
    assign lo_th = DW'(sat_sub(32'(mid), 32'(HYST)));

    // Next state and crossing pulse; state frozen while the signal is too small.
    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        case (state_q)
            ST_INIT: if (arm) state_d = ST_LOW;
            ST_LOW: begin
                if (en && (data_in >= hi_th)) begin
                    state_d = ST_HIGH;
                    rise    = 1'b1;
                end
            end
            ST_HIGH: if (en && (data_in <= lo_th)) state_d = ST_LOW;
            default: state_d = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_INIT;
        else      state_q <= state_d;
    end

endmodule

// File: rtl/signal_meas.sv
// Windowed min/max/pp/mid measurement and gated crossing-frequency counter.
module signal_meas
    import signal_meas_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int WIN_CYC   = DEF_WIN_CYC,
    parameter int FRE_WIN   = DEF_FRE_WIN,
    parameter int FRE_SCALE = DEF_FRE_SCALE,
    parameter int HYST      = DEF_HYST,
    parameter int MIN_PP    = DEF_MIN_PP,
    parameter int CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] max,
    output logic [DW-1:0] min,
    output logic [DW-1:0] pp,
    output logic [DW-1:0] mid,
    output logic          meas_vld,
    output logic [31:0]   fre,
    output logic          fre_vld,
    output logic          sig_ok
);

    localparam int WCW = $clog2(WIN_CYC);
    localparam int GCW = $clog2(FRE_WIN);

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [GCW-1:0] gcnt_q, gcnt_d;
    logic [DW-1:0]  run_max_q, run_max_d, run_min_q, run_min_d;
    logic [DW-1:0]  max_q, max_d, min_q, min_d, pp_q, pp_d, mid_q, mid_d;
    logic           meas_vld_q, sig_ok_q, sig_ok_d;
    logic [CW-1:0]  edge_cnt_q, edge_cnt_d;
    logic [31:0]    fre_q, fre_d;
    logic           fre_vld_q;

    logic          w_term, g_term, rise;
    logic [DW-1:0] fold_max, fold_min, fold_pp;
    logic [CW:0]   cnt_tot;
    logic [31:0]   fre_prod;

    assign w_term = (wcnt_q == WCW'(WIN_CYC - 1));
    assign g_term = (gcnt_q == GCW'(FRE_WIN - 1));

    // Current sample folded into the running extremes; either or both may move.
    assign fold_max = (data_in > run_max_q) ? data_in : run_max_q;
    assign fold_min = (data_in < run_min_q) ? data_in : run_min_q;
    assign fold_pp  = fold_max - fold_min;

    // Terminal-cycle crossing belongs to the gate that is closing.
    assign cnt_tot  = {1'b0, edge_cnt_q} + {{CW{1'b0}}, rise};
    assign fre_prod = 32'(cnt_tot) * 32'(FRE_SCALE);

    hyst_edge_det #(.DW(DW), .HYST(HYST)) u_det (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .mid     (mid_q),
        .arm     (meas_vld_q),
        .en      (sig_ok_q),
        .rise    (rise)
    );

    // Next-state for window, publish and gate logic.
    always_comb begin
        wcnt_d     = w_term ? '0 : wcnt_q + WCW'(1);
        gcnt_d     = g_term ? '0 : gcnt_q + GCW'(1);
        run_max_d  = fold_max;
        run_min_d  = fold_min;
        max_d      = max_q;
        min_d      = min_q;
        pp_d       = pp_q;
        mid_d      = mid_q;
        sig_ok_d   = sig_ok_q;
        edge_cnt_d = edge_cnt_q;
        fre_d      = fre_q;
        if (w_term) begin
            max_d     = fold_max;
            min_d     = fold_min;
            pp_d      = fold_pp;
            mid_d     = DW'(({1'b0, fold_max} + {1'b0, fold_min}) >> 1);
            sig_ok_d  = (32'(fold_pp) >= 32'(MIN_PP));
            run_max_d = '0;
            run_min_d = '1;
        end
        if (g_term) begin
            fre_d      = sig_ok_q ? fre_prod : 32'd0;
            edge_cnt_d = '0;
        end else if (rise && (edge_cnt_q != {CW{1'b1}})) begin
            edge_cnt_d = edge_cnt_q + CW'(1);
        end
    end

    // All state registers; reset discards any partial window or gate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q     <= '0;
            gcnt_q     <= '0;
            run_max_q  <= '0;
            run_min_q  <= '1;
            max_q      <= '0;
            min_q      <= '0;
            pp_q       <= '0;
            mid_q      <= '0;
            sig_ok_q   <= 1'b0;
            meas_vld_q <= 1'b0;
            edge_cnt_q <= '0;
            fre_q      <= '0;
            fre_vld_q  <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            gcnt_q     <= gcnt_d;
            run_max_q  <= run_max_d;
            run_min_q  <= run_min_d;
            max_q      <= max_d;
            min_q      <= min_d;
            pp_q       <= pp_d;
            mid_q      <= mid_d;
            sig_ok_q   <= sig_ok_d;
            meas_vld_q <= w_term;
            edge_cnt_q <= edge_cnt_d;
            fre_q      <= fre_d;
            fre_vld_q  <= g_term;
        end
    end

    assign max      = max_q;
    assign min      = min_q;
    assign pp       = pp_q;
    assign mid      = mid_q;
    assign meas_vld = meas_vld_q;
    assign fre      = fre_q;
    assign fre_vld  = fre_vld_q;
    assign sig_ok   = sig_ok_q;

endmodule

// File: tb/tb_signal_meas.sv
// Directed scoreboard bench for signal_meas.
module tb_signal_meas;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] mx, mn, pp, md;
    logic          meas_vld, fre_vld, sig_ok;
    logic [31:0]   fre;

    signal_meas #(
        .DW(DW), .WIN_CYC(16), .FRE_WIN(64), .FRE_SCALE(1),
        .HYST(4), .MIN_PP(8), .CW(24)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .max(mx), .min(mn), .pp(pp), .mid(md), .meas_vld(meas_vld),
        .fre(fre), .fre_vld(fre_vld), .sig_ok(sig_ok)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int mx; int mn; int pp; int md; int ok; } meas_t;
    typedef struct { int t; int f; } fre_t;

    meas_t mq[$];
    fre_t  fq[$];
    int    tk;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (tick %0d)", tag, obs, exp, tk);
        end
    endtask

    // Expected window result; pp and mid derived from the extremes.
    task automatic pm(input int t, input int hi, input int lo);
        meas_t m;
        m.t = t; m.mx = hi; m.mn = lo; m.pp = hi - lo; m.md = (hi + lo) / 2;
        m.ok = (hi - lo >= 8) ? 1 : 0;
        mq.push_back(m);
    endtask

    task automatic pf(input int t, input int f);
        fre_t x;
        x.t = t; x.f = f;
        fq.push_back(x);
    endtask

    // Drive one sample, then check strobes against the scoreboard heads.
    task automatic tick(input int d);
        bit    ev;
        meas_t m;
        fre_t  x;
        data_in = 10'(d);
        @(posedge clk);
        #1;
        tk++;
        ev = (mq.size() > 0) && (mq[0].t == tk);
        chk("meas_vld", meas_vld, ev);
        if (ev) begin
            m = mq.pop_front();
            chk("max", mx, m.mx);
            chk("min", mn, m.mn);
            chk("pp", pp, m.pp);
            chk("mid", md, m.md);
            chk("sig_ok", sig_ok, m.ok);
        end
        ev = (fq.size() > 0) && (fq[0].t == tk);
        chk("fre_vld", fre_vld, ev);
        if (ev) begin
            x = fq.pop_front();
            chk("fre", fre, x.f);
        end
    endtask

    // Assert reset, check outputs clear asynchronously, then release.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_max", mx, 0);
        chk("rst_min", mn, 0);
        chk("rst_pp", pp, 0);
        chk("rst_mid", md, 0);
        chk("rst_meas_vld", meas_vld, 0);
        chk("rst_fre", fre, 0);
        chk("rst_fre_vld", fre_vld, 0);
        chk("rst_sig_ok", sig_ok, 0);
        chk("rst_missing_meas", mq.size(), 0);
        chk("rst_missing_fre", fq.size(), 0);
        mq.delete();
        fq.delete();
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tk  = 0;
    endtask

    function automatic int t5(input int k);
        if (k == 0)  return 200;
        if (k < 20)  return 0;
        if (k <= 40) return 200;
        if (k < 63)  return 0;
        if (k == 63) return 200;
        return ((k % 16) < 8) ? 0 : 200;
    endfunction

    initial begin
        tk = 0;
        #3;
        do_reset();

        // Ramp over one window.
        pm(16, 115, 100);
        for (int i = 0; i < 16; i++) tick(100 + i);

        // Single spike, then constant: second window must start empty.
        do_reset();
        pm(16, 900, 50);
        pm(32, 50, 50);
        tick(900);
        repeat (31) tick(50);

        // Square wave 0/200 period 8, then dither +-3 around 100.
        do_reset();
        for (int n = 1; n <= 8; n++)  pm(16 * n, 200, 0);
        for (int n = 9; n <= 12; n++) pm(16 * n, 103, 97);
        pf(64, 6);
        pf(128, 8);
        pf(192, 0);
        for (int k = 0; k < 128; k++)   tick((((k / 4) % 2) != 0) ? 200 : 0);
        for (int k = 128; k < 192; k++) tick(((k % 2) != 0) ? 103 : 97);

        // Flat input for three gates.
        do_reset();
        for (int n = 1; n <= 12; n++) pm(16 * n, 500, 500);
        pf(64, 0);
        pf(128, 0);
        pf(192, 0);
        repeat (192) tick(500);

        // Crossing on the last gate cycle lands in the closing gate; next gate restarts.
        do_reset();
        for (int n = 1; n <= 8; n++) pm(16 * n, 200, 0);
        pf(64, 2);
        pf(128, 4);
        for (int k = 0; k < 128; k++) tick(t5(k));

        // Reset at wcnt=7 of the second window: partial window discarded.
        do_reset();
        pm(16, 115, 100);
        for (int i = 0; i < 16; i++) tick(100 + i);
        tick(900);
        repeat (6) tick(120);
        do_reset();
        pm(16, 300, 300);
        repeat (16) tick(300);
        chk("end_missing_meas", mq.size(), 0);
        chk("end_missing_fre", fq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signal_meas.md
Name: signal_meas

Overview:
- Parametrised successor to the single-channel ADC min/max/frequency quantiser. It sits directly behind the ADC sample register.
- Per window: measures min, max, peak-to-peak and midpoint of the sampled waveform.
- Per gate: counts rising crossings with hysteresis around the measured midpoint and publishes a scaled frequency.
- All results are registered, with one-cycle valid strobes for the display and report logic.

Parameters:
DW, 10, sample width in bits
WIN_CYC, 1000000, min/max window length in clk cycles (≥2)
FRE_WIN, 5000000, frequency gate length in clk cycles (≥2)
FRE_SCALE, 10, multiplier from crossings-per-gate to Hz (CLK_HZ/FRE_WIN)
HYST, 4, hysteresis half-band in LSBs
MIN_PP, 8, minimum peak-to-peak for a valid signal
CW, 24, crossing counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
data_in  in  DW  ADC sample, one per clk
max  out  DW  last published window maximum
min  out  DW  last published window minimum
pp  out  DW  max-min
mid  out  DW  (max+min)>>1, computed on DW+1 bits, then truncated
meas_vld  out  1  one-cycle pulse when max/min/pp/mid update
fre  out  32  crossings in last gate × FRE_SCALE
fre_vld  out  1  one-cycle pulse when fre updates
sig_ok  out  1  last published pp ≥ MIN_PP

Behaviour:
- Reset: asynchronous on rst=0. All outputs 0. Running max = 0, running min = all-ones. Counters 0. Detector state INIT.
- Window counter wcnt: counts 0..WIN_CYC-1, then wraps to 0.
- Running min and max update independently every cycle. A sample may update both (no else-if priority).
- Terminal cycle (wcnt=WIN_CYC-1):
  - max/min are published as the fold of running values with that cycle's data_in; pp, mid and sig_ok are published from these.
  - meas_vld=1 on the next cycle edge (outputs and strobe change together, latency 1 clk).
  - Running registers reload to 0 / all-ones, so the next window starts empty.
- Hysteresis detector states: INIT, LOW, HIGH.
  - Thresholds: hi_th = min(mid+HYST, 2^DW-1) and lo_th = max(mid-HYST, 0), both saturating. They come from the registered mid, so a crossing on the publish cycle uses the old mid.
  - INIT → LOW on the first meas_vld.
  - LOW → HIGH when data_in ≥ hi_th; counts one crossing.
  - HIGH → LOW when data_in ≤ lo_th.
  - While sig_ok=0: state is held, and LOW→HIGH transitions are not counted.
- Crossing counter edge_cnt saturates at 2^CW-1.
- Gate counter gcnt: counts 0..FRE_WIN-1.
  - At terminal: fre ← (edge_cnt + crossing_this_cycle) × FRE_SCALE, truncated to 32 bits; fre_vld pulses; edge_cnt ← 0.
  - A crossing on the terminal cycle is counted in the closing gate.
  - fre = 0 if sig_ok=0 at the terminal cycle.
- Window and gate run independently. Simultaneous terminals produce both strobes on the same cycle.
- Reset mid-window or mid-gate: partial results are discarded and no strobe is produced.

Decomposition:
- Package signal_meas_pkg holds:
  - detector state encoding (ST_INIT=2'd0, ST_LOW=2'd1, ST_HIGH=2'd2);
  - saturating add/sub functions for the thresholds;
  - default parameter constants.
- Sub-module hyst_edge_det: state machine plus thresholds.
  - Inputs: clk, rst, data_in, mid, arm, en.
  - Output: rise pulse.
- Top level keeps the window/gate counters, min/max folding and the fre multiply.

Test Plan:
- Common parameters: WIN_CYC=16, FRE_WIN=64, HYST=4, MIN_PP=8, FRE_SCALE=1, DW=10.
- Ramp data_in 100..115 over one window → meas_vld at cycle 16 with max=115, min=100, pp=15, mid=107, sig_ok=1.
- Single sample 900 in the first window, then a constant 50 → window 1 max=900, min=50. Window 2 max=50, min=50, pp=0, sig_ok=0, which proves the running reload.
- Square wave 0/200 with period 8 → after arming, gate 2 reports fre=8. Dither ±3 around mid=100 → no crossings counted, fre=0 (hysteresis).
- Flat 500 input for 3 gates → fre_vld pulses at 64, 128, 192 with fre=0. Detector stays in INIT/LOW.
- Crossing injected exactly on gcnt=63 → included in the closing gate count. Next gate starts at 0.
- Assert rst low at wcnt=7 → all outputs 0 immediately (asynchronous). No meas_vld until 16 cycles after release.
